// File: rtl/rr_arb_pkg.sv
// Shared types and helpers for the round-robin select arbiter.
// Used by rr_priority_pick and rr_mux_select_arb.
package rr_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Modulo increment: wraps depth-1 back to 0.
    function automatic int rr_next_idx(input int idx, input int depth);
        return (idx >= depth - 1) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational rotating priority encoder: first set request at or after ptr,
// wrapping through DEPTH-1 back to 0.
module rr_priority_pick #(
    parameter int DEPTH = 8,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic [DEPTH-1:0] i_req,
    input  logic [SEL_W-1:0] ptr,
    output logic             o_any,
    output logic [SEL_W-1:0] o_idx
);

    logic [2*DEPTH-1:0] req_dbl;
    logic [DEPTH-1:0]   req_rot;
    logic [SEL_W-1:0]   offset;
    int                 sum;

    // Rotate so bit 0 of req_rot is the request at ptr.
    assign req_dbl = {i_req, i_req};
    assign req_rot = req_dbl[ptr +: DEPTH];
    assign o_any   = |req_rot;

    // NOTE: every variable gets a default at the top of always_comb; a missed
    // branch would otherwise infer a latch.
    always_comb begin
        offset = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (req_rot[k]) offset = SEL_W'(k);
        end
        sum = int'(ptr) + int'(offset);
        if (sum >= DEPTH) sum = sum - DEPTH;
        o_idx = SEL_W'(sum);
    end

endmodule

// File: rtl/rr_mux_select_arb.sv
// Round-robin arbiter driving a word mux select with a valid/ready handshake.
// Define RR_ARB_LOCK_EN to hold a grant across beats until an accept with i_last=1.
module rr_mux_select_arb
    import rr_arb_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int SEL_W = $clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [DEPTH-1:0] i_req,
    input  logic             i_last,
    input  logic             i_ready,
    output logic             o_valid,
    output logic [SEL_W-1:0] o_select,
    output logic [DEPTH-1:0] o_grant
);

    arb_state_t       state_q, state_d;
    logic [SEL_W-1:0] ptr_q, ptr_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic [DEPTH-1:0] grant_q, grant_d;
    logic [SEL_W-1:0] next_sel, pick_ptr, pick_idx;
    logic             pick_any, accept, rotate;

    assign accept   = (state_q == GRANT) && i_ready;
    assign next_sel = SEL_W'(rr_next_idx(int'(sel_q), DEPTH));

`ifdef RR_ARB_LOCK_EN
    assign rotate = accept && i_last;
`else
    logic unused_last;
    assign unused_last = i_last;
    assign rotate      = accept;
`endif

    // On rotation, arbitrate this cycle against the already-advanced pointer.
    assign pick_ptr = rotate ? next_sel : ptr_q;

    rr_priority_pick #(
        .DEPTH (DEPTH),
        .SEL_W (SEL_W)
    ) u_pick (
        .i_req (i_req),
        .ptr   (pick_ptr),
        .o_any (pick_any),
        .o_idx (pick_idx)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        grant_d = grant_q;
        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d = GRANT;
                    sel_d   = pick_idx;
                    grant_d = DEPTH'(1) << pick_idx;
                end
            end
            GRANT: begin
                if (rotate) begin
                    ptr_d = next_sel;
                    if (pick_any) begin
                        sel_d   = pick_idx;
                        grant_d = DEPTH'(1) << pick_idx;
                    end else begin
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                grant_d = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            sel_q   <= '0;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            grant_q <= grant_d;
        end
    end

    assign o_valid  = (state_q == GRANT);
    assign o_select = sel_q;
    assign o_grant  = grant_q;

endmodule
